// File: rtl/wishbone_sram_bridge_if.sv
// Wishbone classic bus bundle between a bus master and wishbone_sram_bridge.
interface wishbone_sram_bridge_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wishbone_sram_bridge.sv
// Wishbone classic slave fronting NUM_BANKS single-port SRAM macros with a fixed read latency.
// Define WB_SRAM_ERR_EN to answer out-of-window requests on wbs_err_o instead of a zero-data ack.
module wishbone_sram_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          NUM_BANKS  = 2,
    parameter int          RAM_DELAY  = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    wishbone_sram_bridge_if.slave     wb,
`ifdef WB_SRAM_ERR_EN
    output logic                      wbs_err_o,
`endif
    output logic                      ram_clk0,
    output logic [NUM_BANKS-1:0]      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_dout0,
    input  logic [32*NUM_BANKS-1:0]   ram_din0
);
    localparam int          BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int          CNT_W     = $clog2(RAM_DELAY + 1);
    localparam logic [32:0] WIN_BYTES = 33'(NUM_BANKS) << (ADDR_WIDTH + 2);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t                state_q, state_d;
    logic [NUM_BANKS-1:0]  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           dout_q, dout_d;
    logic [31:0]           rdat_q, rdat_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
`ifdef WB_SRAM_ERR_EN
    logic                  err_q, err_d;
`endif

    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [BANK_W-1:0]     req_bank;
    logic [NUM_BANKS-1:0]  req_csb;
    logic [31:0]           bank_rdata;

    // Window decode works on the offset so a window reaching the top of the address space stays correct.
    assign offset   = wb.wbs_adr_i - BASE_ADDR;
    assign in_range = (wb.wbs_adr_i >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    assign req_word = offset[ADDR_WIDTH+1:2];
    assign req_bank = (NUM_BANKS > 1) ? offset[ADDR_WIDTH+2 +: BANK_W] : '0;

    always_comb begin
        req_csb    = '1;
        bank_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_csb[b] = (req_bank != BANK_W'(b));
            if (bank_q == BANK_W'(b)) begin
                bank_rdata = ram_din0[32*b +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        csb_d   = '1;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdat_d  = rdat_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
`ifdef WB_SRAM_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                    if (in_range) begin
                        state_d = ACCESS;
                        csb_d   = req_csb;
                        web_d   = ~wb.wbs_we_i;
                        wmask_d = wb.wbs_sel_i;
                        addr_d  = req_word;
                        dout_d  = wb.wbs_dat_i;
                        bank_d  = req_bank;
                    end else begin
                        state_d = ACK;
`ifdef WB_SRAM_ERR_EN
                        err_d   = 1'b1;
`else
                        ack_d   = 1'b1;
                        if (!wb.wbs_we_i) begin
                            rdat_d = '0;
                        end
`endif
                    end
                end
            end
            ACCESS: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(RAM_DELAY);
            end
            WAIT: begin
                // An abandoned cycle leaves the SRAM access in flight but never reports it.
                if (!wb.wbs_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    if (web_q) begin
                        rdat_d = bank_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdat_q  <= '0;
            bank_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
`ifdef WB_SRAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdat_q  <= rdat_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
`ifdef WB_SRAM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Responses are qualified by cyc so a master that abandons the cycle during ACK sees nothing.
    assign wb.wbs_ack_o = ack_q & wb.wbs_cyc_i;
    assign wb.wbs_dat_o = rdat_q;
`ifdef WB_SRAM_ERR_EN
    assign wbs_err_o    = err_q & wb.wbs_cyc_i;
`endif
    assign ram_clk0     = wb_clk_i;
    assign ram_csb0     = csb_q;
    assign ram_web0     = web_q;
    assign ram_wmask0   = wmask_q;
    assign ram_addr0    = addr_q;
    assign ram_dout0    = dout_q;
endmodule

// File: tb/tb_wishbone_sram_bridge.sv
// Scoreboard bench: two bridges (RAM_DELAY 1 and 3) against behavioural SRAMs and a window/memory reference model.
module tb_wishbone_sram_bridge;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int AW  = 8;
    localparam int NB  = 2;
    localparam int RD0 = 1;
    localparam int RD1 = 3;
`ifdef WB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct { int inst; int cyc; logic is_err; logic [31:0] dat; } resp_t;
    typedef struct { int inst; int cyc; logic [1:0] csb; logic web; logic [3:0] wmask;
                     logic [7:0] addr; logic [31:0] dout; } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    logic [1:0]        stb, cyc, we;
    logic [1:0][3:0]   sel;
    logic [1:0][31:0]  wdat, adr;
    logic [1:0]        ack, err, rclk, web;
    logic [1:0][31:0]  dat_r, rdout;
    logic [1:0][1:0]   csb;
    logic [1:0][3:0]   wmask;
    logic [1:0][7:0]   raddr;
    logic [1:0][63:0]  din;

    wishbone_sram_bridge_if bus0();
    wishbone_sram_bridge_if bus1();

    assign bus0.wbs_stb_i = stb[0];  assign bus1.wbs_stb_i = stb[1];
    assign bus0.wbs_cyc_i = cyc[0];  assign bus1.wbs_cyc_i = cyc[1];
    assign bus0.wbs_we_i  = we[0];   assign bus1.wbs_we_i  = we[1];
    assign bus0.wbs_sel_i = sel[0];  assign bus1.wbs_sel_i = sel[1];
    assign bus0.wbs_dat_i = wdat[0]; assign bus1.wbs_dat_i = wdat[1];
    assign bus0.wbs_adr_i = adr[0];  assign bus1.wbs_adr_i = adr[1];
    assign ack[0]   = bus0.wbs_ack_o; assign ack[1]   = bus1.wbs_ack_o;
    assign dat_r[0] = bus0.wbs_dat_o; assign dat_r[1] = bus1.wbs_dat_o;
`ifndef WB_SRAM_ERR_EN
    assign err = 2'b00;
`endif

    wishbone_sram_bridge #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RAM_DELAY(RD0)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus0),
`ifdef WB_SRAM_ERR_EN
        .wbs_err_o(err[0]),
`endif
        .ram_clk0(rclk[0]), .ram_csb0(csb[0]), .ram_web0(web[0]), .ram_wmask0(wmask[0]),
        .ram_addr0(raddr[0]), .ram_dout0(rdout[0]), .ram_din0(din[0]));

    wishbone_sram_bridge #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RAM_DELAY(RD1)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus1),
`ifdef WB_SRAM_ERR_EN
        .wbs_err_o(err[1]),
`endif
        .ram_clk0(rclk[1]), .ram_csb0(csb[1]), .ram_web0(web[1]), .ram_wmask0(wmask[1]),
        .ram_addr0(raddr[1]), .ram_dout0(rdout[1]), .ram_din0(din[1]));

    function automatic logic [31:0] init_val(input int i, input int b, input int a);
        if (i == 0 && b == 1 && a == 1) return 32'h1234_5678;
        return {4'hA, 4'(i), 4'(b), 4'h0, 8'(a), 8'(a) ^ 8'h3C};
    endfunction

    // Behavioural SRAM macros: capture on a low chip select, read data RAM_DELAY cycles later.
    logic [31:0] mem  [2][2][256];
    logic [31:0] pipe [2][2][4];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2; i++)
                for (int b = 0; b < 2; b++)
                    for (int a = 0; a < 256; a++) mem[i][b][a] <= init_val(i, b, a);
            mem_ready <= 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 3; s > 0; s--) pipe[i][b][s] <= pipe[i][b][s-1];
                pipe[i][b][0] <= 32'hBADC_0FFE;
                if (mem_ready && !csb[i][b]) begin
                    if (!web[i]) begin
                        for (int k = 0; k < 4; k++)
                            if (wmask[i][k]) mem[i][b][raddr[i]][8*k +: 8] <= rdout[i][8*k +: 8];
                    end else begin
                        pipe[i][b][0] <= mem[i][b][raddr[i]];
                    end
                end
            end
        end
    end
    assign din[0] = {pipe[0][1][RD0-1], pipe[0][0][RD0-1]};
    assign din[1] = {pipe[1][1][RD1-1], pipe[1][0][RD1-1]};

    // Reference model state
    logic [31:0] ref_mem [2][2][256];
    logic [31:0] last_rd [2];
    resp_t rq[$];
    acc_t  aq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin : monitor
        resp_t r;
        acc_t  x;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (ack[i] || err[i]) begin
                    if (rq.size() == 0) chk("unexpected_resp", {31'b0, ack[i] | err[i]}, 32'd0);
                    else begin
                        r = rq.pop_front();
                        chk("resp_inst", i, r.inst);
                        chk("resp_cycle", cycle, r.cyc);
                        chk("resp_err", {31'b0, err[i]}, {31'b0, r.is_err});
                        chk("resp_ack", {31'b0, ack[i]}, {31'b0, ~r.is_err});
                        if (!r.is_err) chk("resp_data", dat_r[i], r.dat);
                    end
                end
                if (csb[i] != 2'b11) begin
                    if (aq.size() == 0) chk("unexpected_access", {30'b0, csb[i]}, 32'd3);
                    else begin
                        x = aq.pop_front();
                        chk("acc_inst", i, x.inst);
                        chk("acc_cycle", cycle, x.cyc);
                        chk("acc_csb", {30'b0, csb[i]}, {30'b0, x.csb});
                        chk("acc_web", {31'b0, web[i]}, {31'b0, x.web});
                        chk("acc_wmask", {28'b0, wmask[i]}, {28'b0, x.wmask});
                        chk("acc_addr", {24'b0, raddr[i]}, {24'b0, x.addr});
                        chk("acc_dout", rdout[i], x.dout);
                    end
                end
            end
        end
    end

    task automatic check_reset(input int i);
        chk("rst_csb", {30'b0, csb[i]}, 32'd3);
        chk("rst_web", {31'b0, web[i]}, 32'd1);
        chk("rst_wmask", {28'b0, wmask[i]}, 32'd0);
        chk("rst_addr", {24'b0, raddr[i]}, 32'd0);
        chk("rst_dout", rdout[i], 32'd0);
        chk("rst_ack", {31'b0, ack[i]}, 32'd0);
        chk("rst_dat", dat_r[i], 32'd0);
        chk("ram_clk", {31'b0, rclk[i]}, {31'b0, clk});
`ifdef WB_SRAM_ERR_EN
        chk("rst_err", {31'b0, err[i]}, 32'd0);
`endif
    endtask

    task automatic wait_access(input int i);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (csb[i] == 2'b11 && k < 10);
        if (csb[i] == 2'b11) chk("access_timeout", {30'b0, csb[i]}, 32'd0);
    endtask

    // mode 0: normal transfer, 1: drop cyc in WAIT, 2: assert reset during ACCESS
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int mode);
        resp_t r;
        acc_t  x;
        logic [31:0] off;
        bit inr;
        int b, wd, rd, k, acc_cyc;
        rd      = (i == 0) ? RD0 : RD1;
        off     = a - BASE;
        inr     = (a >= BASE) && (off < 32'(NB * 4 * (1 << AW)));
        b       = int'(off >> (AW + 2));
        wd      = int'((off >> 2) & 32'hFF);
        acc_cyc = cycle + 1;
        r.inst = i; r.is_err = 1'b0; r.dat = last_rd[i];
        r.cyc  = inr ? acc_cyc + 1 + rd : acc_cyc;
        if (inr) begin
            x.inst = i; x.cyc = acc_cyc; x.csb = ~(2'b01 << b); x.web = ~w;
            x.wmask = s; x.addr = 8'(wd); x.dout = d;
            aq.push_back(x);
            if (w) begin
                if (mode != 2)
                    for (int k2 = 0; k2 < 4; k2++) if (s[k2]) ref_mem[i][b][wd][8*k2 +: 8] = d[8*k2 +: 8];
            end else if (mode == 0) begin
                r.dat = ref_mem[i][b][wd];
                last_rd[i] = r.dat;
            end
        end else if (ERR_EN) begin
            r.is_err = 1'b1;
        end else if (!w) begin
            r.dat = '0;
            last_rd[i] = '0;
        end
        if (mode == 0) rq.push_back(r);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; wdat[i] = d;
        if (mode == 0) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!(ack[i] || err[i]) && k < 20);
            if (!(ack[i] || err[i])) chk("resp_timeout", {31'b0, ack[i] | err[i]}, 32'd1);
            @(posedge clk); #1;
            cyc[i] = 1'b0; stb[i] = 1'b0;
        end else if (mode == 1) begin
            wait_access(i);
            @(negedge clk);
            cyc[i] = 1'b0; stb[i] = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("drop_no_ack", {31'b0, ack[i] | err[i]}, 32'd0);
            end
            @(posedge clk); #1;
        end else begin
            wait_access(i);
            #2 rst_n = 1'b0;
            #1;
            check_reset(0);
            check_reset(1);
            cyc[i] = 1'b0; stb[i] = 1'b0;
            last_rd[0] = '0; last_rd[1] = '0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        int          kind, g;
        stb = '0; cyc = '0; we = '0; sel = '0; wdat = '0; adr = '0;
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = '0;
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < 256; j++) ref_mem[i][b][j] = init_val(i, b, j);
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;

        xfer(0, 1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 0);
        xfer(0, 1'b0, 32'h3000_0404, 4'hF, 32'h0, 0);
        xfer(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 0);
        xfer(0, 1'b0, 32'h3000_0800, 4'hF, 32'h0, 0);
        xfer(0, 1'b1, 32'h2FFF_FFFC, 4'hF, 32'h5555_AAAA, 0);
        xfer(0, 1'b1, 32'h3000_07FC, 4'b0101, 32'hCAFE_F00D, 0);
        xfer(0, 1'b0, 32'h3000_07FC, 4'hF, 32'h0, 0);
        xfer(0, 1'b1, 32'h3000_0010, 4'b0110, 32'h1357_9BDF, 1);
        xfer(0, 1'b0, 32'h3000_0010, 4'hF, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = BASE + 32'h800 + (32'($urandom_range(0, 255)) << 2);
            else if (kind == 1) a = BASE - (32'($urandom_range(1, 64)) << 2);
            else                a = BASE + (32'($urandom_range(0, 511)) << 2);
            w = 1'($urandom_range(0, 1));
            xfer(0, w, a, 4'($urandom_range(0, 15)), $urandom, 0);
            g = $urandom_range(0, 2);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end

        xfer(1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 0);
        xfer(1, 1'b1, 32'h3000_0408, 4'b1001, 32'hA1B2_C3D4, 0);
        xfer(1, 1'b0, 32'h3000_0408, 4'hF, 32'h0, 0);
        xfer(1, 1'b0, 32'h3000_0900, 4'hF, 32'h0, 0);
        xfer(1, 1'b1, 32'h3000_0020, 4'hF, 32'h0BAD_CAFE, 1);
        xfer(1, 1'b0, 32'h3000_0020, 4'hF, 32'h0, 0);

        xfer(0, 1'b0, 32'h3000_0404, 4'hF, 32'h0, 2);
        xfer(0, 1'b0, 32'h3000_0404, 4'hF, 32'h0, 0);
        xfer(1, 1'b1, 32'h3000_0044, 4'hF, 32'h7777_8888, 0);
        xfer(1, 1'b0, 32'h3000_0044, 4'hF, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("acc_queue_empty", aq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
